// File: rtl/client_tx_pkg.sv
// Shared types and helpers for the client transmit multiplexer.
// Used by client_tx_mux and its rr_arbiter sub-module.
package client_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam int STATS_W = 16;

   // Low bit index of channel ch within a flat bus of w-bit slices.
   function automatic int slice_lo(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/client_tx_mux_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after the last grant.
// Searches last+1 upward and wraps modulo N_CH.
module rr_arbiter #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] last,
   output logic [$clog2(N_CH)-1:0] next,
   output logic                    valid
);

   localparam int GW = $clog2(N_CH);

   int idx;

   always_comb begin
      next  = last;
      valid = 1'b0;
      idx   = 0;
      for (int off = 1; off <= N_CH; off++) begin
         idx = (int'(last) + off) % N_CH;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            next  = idx[GW-1:0];
         end
      end
   end

endmodule

// File: rtl/client_tx_mux.sv
// N-channel round-robin transmit multiplexer onto one client Tx port.
// Optional per-channel packet counters: define CLIENT_TX_MUX_STATS_EN.
//
// state | meaning
// IDLE  | waiting for any req, arbiter picks next channel
// REQ   | up_req held to Tx port, up_ack routed to granted channel
// XFER  | byte strobes routed to granted channel until the stream ends
module client_tx_mux
   import client_tx_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int JUMBO_DW = 14,
   parameter int DW       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req,
   input  logic [N_CH*JUMBO_DW-1:0] length,
   input  logic [N_CH*DW-1:0]       data_in,
   output logic [N_CH-1:0]          ack,
   output logic [N_CH-1:0]          strobe,
   output logic                     up_req,
   output logic [JUMBO_DW-1:0]      up_length,
   input  logic                     up_ack,
   input  logic                     up_strobe,
   output logic [DW-1:0]            up_data,
   output logic [$clog2(N_CH)-1:0]  grant
`ifdef CLIENT_TX_MUX_STATS_EN
   ,
   output logic [N_CH*STATS_W-1:0]  pkt_cnt
`endif
);

   localparam int GW = $clog2(N_CH);

   state_t              state;
   logic                seen_strobe;
   logic                xfer_done;
   logic [GW-1:0]       arb_next;
   logic                arb_valid;
   logic [N_CH-1:0]     grant_oh;
   logic [JUMBO_DW-1:0] len_a [N_CH];
   logic [DW-1:0]       dat_a [N_CH];

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req   (req),
      .last  (grant),
      .next  (arb_next),
      .valid (arb_valid)
   );

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         len_a[i] = length[slice_lo(i, JUMBO_DW) +: JUMBO_DW];
         dat_a[i] = data_in[slice_lo(i, DW) +: DW];
      end
   end

   always_comb begin
      grant_oh        = '0;
      grant_oh[grant] = 1'b1;
   end

   // A zero-length packet has no bytes, so it leaves XFER after one cycle.
   assign xfer_done = (state == XFER) &&
                      ((up_length == '0) || (seen_strobe && !up_strobe));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= GW'(N_CH - 1);
         up_req      <= 1'b0;
         up_length   <= '0;
         seen_strobe <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant     <= arb_next;
                  up_req    <= 1'b1;
                  up_length <= len_a[arb_next];
                  state     <= REQ;
               end
            end
            REQ: begin
               if (up_ack) begin
                  up_req      <= 1'b0;
                  seen_strobe <= 1'b0;
                  state       <= XFER;
               end
            end
            XFER: begin
               if (xfer_done) state <= IDLE;
               else if (up_strobe) seen_strobe <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Routing is gated by rst so an aborted transfer sees nothing in the reset cycle.
   assign ack     = (!rst && state == REQ  && up_ack)    ? grant_oh : '0;
   assign strobe  = (!rst && state == XFER && up_strobe) ? grant_oh : '0;
   assign up_data = dat_a[grant];

`ifdef CLIENT_TX_MUX_STATS_EN
   logic [STATS_W-1:0] cnt_q [N_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else if (xfer_done) begin
         cnt_q[grant] <= cnt_q[grant] + 1'b1;
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int i = 0; i < N_CH; i++) pkt_cnt[slice_lo(i, STATS_W) +: STATS_W] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_client_tx_mux.sv
// Directed self-checking bench for client_tx_mux (4 channels).
module tb_client_tx_mux;

   localparam int N_CH     = 4;
   localparam int JUMBO_DW = 14;
   localparam int DW       = 8;

   logic                     clk;
   logic                     rst;
   logic [N_CH-1:0]          req;
   logic [N_CH*JUMBO_DW-1:0] length;
   logic [N_CH*DW-1:0]       data_in;
   logic [N_CH-1:0]          ack;
   logic [N_CH-1:0]          strobe;
   logic                     up_req;
   logic [JUMBO_DW-1:0]      up_length;
   logic                     up_ack;
   logic                     up_strobe;
   logic [DW-1:0]            up_data;
   logic [1:0]               grant;
`ifdef CLIENT_TX_MUX_STATS_EN
   logic [N_CH*16-1:0]       pkt_cnt;
`endif

   int checks = 0;
   int errors = 0;

   client_tx_mux #(.N_CH(N_CH), .JUMBO_DW(JUMBO_DW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .length    (length),
      .data_in   (data_in),
      .ack       (ack),
      .strobe    (strobe),
      .up_req    (up_req),
      .up_length (up_length),
      .up_ack    (up_ack),
      .up_strobe (up_strobe),
      .up_data   (up_data),
      .grant     (grant)
`ifdef CLIENT_TX_MUX_STATS_EN
      ,
      .pkt_cnt   (pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int ch, input logic [JUMBO_DW-1:0] v);
      length[ch*JUMBO_DW +: JUMBO_DW] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; up_ack = 1'b1; up_strobe = 1'b1;
      length = '0; data_in = 32'hD3C2B1A0;
      tick(); tick();
      checks++; if (up_req !== 1'b0) begin errors++; $display("FAIL reset_up_req got %0b want 0", up_req); end
      checks++; if (up_length !== 14'd0) begin errors++; $display("FAIL reset_up_length got %0d want 0", up_length); end
      checks++; if (grant !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d want 3", grant); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
      checks++; if (strobe !== 4'b0000) begin errors++; $display("FAIL reset_strobe got %b want 0000", strobe); end
      checks++; if (up_data !== 8'hD3) begin errors++; $display("FAIL reset_up_data got %h want d3", up_data); end
      up_ack = 1'b0; up_strobe = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_ch2();
      set_len(0, 14'd9); set_len(1, 14'd9); set_len(2, 14'd5); set_len(3, 14'd9);
      req = 4'b0100;
      tick();
      checks++; if (up_req !== 1'b1) begin errors++; $display("FAIL single_up_req got %0b want 1", up_req); end
      checks++; if (up_length !== 14'd5) begin errors++; $display("FAIL single_up_length got %0d want 5", up_length); end
      checks++; if (grant !== 2'd2) begin errors++; $display("FAIL single_grant got %0d want 2", grant); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_early got %b want 0000", ack); end
      tick();
      checks++; if (up_req !== 1'b1) begin errors++; $display("FAIL single_up_req_held got %0b want 1", up_req); end
      up_ack = 1'b1;
      #1;
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack); end
      tick();
      up_ack = 1'b0; req = '0;
      #1;
      checks++; if (up_req !== 1'b0) begin errors++; $display("FAIL single_up_req_clear got %0b want 0", up_req); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_after got %b want 0000", ack); end
      for (int i = 0; i < 5; i++) begin
         up_strobe = 1'b1;
         data_in[2*DW +: DW] = 8'h40 + 8'(i);
         #1;
         checks++; if (strobe !== 4'b0100) begin errors++; $display("FAIL single_strobe[%0d] got %b want 0100", i, strobe); end
         checks++; if (up_data !== 8'h40 + 8'(i)) begin errors++; $display("FAIL single_up_data[%0d] got %h want %h", i, up_data, 8'h40 + 8'(i)); end
         tick();
      end
      up_strobe = 1'b0;
      #1;
      checks++; if (strobe !== 4'b0000) begin errors++; $display("FAIL single_strobe_low got %b want 0000", strobe); end
      tick();
      // Back in IDLE: stray handshakes must not be routed.
      up_strobe = 1'b1; up_ack = 1'b1;
      #1;
      checks++; if (strobe !== 4'b0000) begin errors++; $display("FAIL stray_strobe got %b want 0000", strobe); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL stray_ack got %b want 0000", ack); end
      tick();
      checks++; if (up_req !== 1'b0) begin errors++; $display("FAIL stray_up_req got %0b want 0", up_req); end
      checks++; if (strobe !== 4'b0000) begin errors++; $display("FAIL stray_strobe2 got %b want 0000", strobe); end
      up_strobe = 1'b0; up_ack = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_seq [5];
      logic [3:0] exp_oh;
      int w;
      exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
      do_reset();
      for (int c = 0; c < N_CH; c++) set_len(c, 14'd1);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_oh = 4'b0001 << exp_seq[k];
         w = 0;
         while (up_req !== 1'b1 && w < 20) begin tick(); w++; end
         checks++; if (up_req !== 1'b1) begin errors++; $display("FAIL rr_timeout[%0d] up_req got %0b want 1", k, up_req); end
         checks++; if (grant !== exp_seq[k]) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant, exp_seq[k]); end
         up_ack = 1'b1;
         #1;
         checks++; if (ack !== exp_oh) begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", k, ack, exp_oh); end
         tick();
         up_ack = 1'b0; up_strobe = 1'b1;
         #1;
         checks++; if (strobe !== exp_oh) begin errors++; $display("FAIL rr_strobe[%0d] got %b want %b", k, strobe, exp_oh); end
         tick();
         up_strobe = 1'b0;
         tick();
      end
      req = '0;
   endtask

   task automatic test_zero_len();
      do_reset();
      set_len(1, 14'd0);
      req = 4'b0010;
      tick();
      checks++; if (up_req !== 1'b1 || grant !== 2'd1) begin errors++; $display("FAIL zero_grant up_req %0b grant %0d want 1 1", up_req, grant); end
      checks++; if (up_length !== 14'd0) begin errors++; $display("FAIL zero_up_length got %0d want 0", up_length); end
      up_ack = 1'b1;
      #1;
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL zero_ack got %b want 0010", ack); end
      tick();
      up_ack = 1'b0; req = '0;
      #1;
      checks++; if (strobe !== 4'b0000 || up_req !== 1'b0) begin errors++; $display("FAIL zero_xfer strobe %b up_req %0b want 0000 0", strobe, up_req); end
      tick();
      // XFER must already be over, so a strobe here is not routed.
      up_strobe = 1'b1;
      #1;
      checks++; if (strobe !== 4'b0000) begin errors++; $display("FAIL zero_no_strobe got %b want 0000", strobe); end
      up_strobe = 1'b0;
      req = 4'b0010;
      tick();
      checks++; if (up_req !== 1'b1) begin errors++; $display("FAIL zero_regrant up_req got %0b want 1", up_req); end
      req = '0;
   endtask

   task automatic test_reset_mid_xfer();
      do_reset();
      set_len(3, 14'd4);
      req = 4'b1000;
      tick();
      up_ack = 1'b1;
      tick();
      up_ack = 1'b0; req = '0; up_strobe = 1'b1;
      #1;
      checks++; if (strobe !== 4'b1000) begin errors++; $display("FAIL mid_strobe got %b want 1000", strobe); end
      tick();
      rst = 1'b1; up_ack = 1'b1;
      #1;
      checks++; if (strobe !== 4'b0000 || ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_cycle strobe %b ack %b want 0000 0000", strobe, ack); end
      tick();
      checks++; if (up_req !== 1'b0 || up_length !== 14'd0) begin errors++; $display("FAIL mid_rst_regs up_req %0b up_length %0d want 0 0", up_req, up_length); end
      checks++; if (grant !== 2'd3) begin errors++; $display("FAIL mid_rst_grant got %0d want 3", grant); end
      rst = 1'b0;
      #1;
      checks++; if (strobe !== 4'b0000 || ack !== 4'b0000) begin errors++; $display("FAIL mid_after_rst strobe %b ack %b want 0000 0000", strobe, ack); end
      tick();
      checks++; if (strobe !== 4'b0000 || up_req !== 1'b0) begin errors++; $display("FAIL mid_after_rst2 strobe %b up_req %0b want 0000 0", strobe, up_req); end
      up_ack = 1'b0; up_strobe = 1'b0;
   endtask

`ifdef CLIENT_TX_MUX_STATS_EN
   task automatic test_stats();
      do_reset();
      set_len(1, 14'd0);
      for (int p = 0; p < 3; p++) begin
         req = 4'b0010;
         tick();
         req = '0; up_ack = 1'b1;
         tick();
         up_ack = 1'b0;
         tick();
         tick();
      end
      checks++; if (pkt_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin errors++; $display("FAIL stats_cnt got %h want 0000000000030000", pkt_cnt); end
      up_ack = 1'b1; up_strobe = 1'b1;
      tick(); tick();
      checks++; if (pkt_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin errors++; $display("FAIL stats_stray got %h want 0000000000030000", pkt_cnt); end
      up_ack = 1'b0; up_strobe = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; req = '0; length = '0; data_in = '0; up_ack = 1'b0; up_strobe = 1'b0;
      test_reset();
      test_single_ch2();
      test_round_robin();
      test_zero_len();
      test_reset_mid_xfer();
`ifdef CLIENT_TX_MUX_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
